// File: rtl/rf_2r1w_sync_pkg.sv
// rf_pkg: shared types and helpers for rf_2r1w_sync (parity helper built only with RF_PARITY_EN)
package rf_pkg;

    localparam int RF_MAX_BIT = 64;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    function automatic logic [RF_MAX_BIT-1:0] rf_merge(
        input logic [RF_MAX_BIT-1:0] old,
        input logic [RF_MAX_BIT-1:0] d,
        input logic [RF_MAX_BIT-1:0] bweb
    );
        return (old & bweb) | (d & ~bweb);
    endfunction

`ifdef RF_PARITY_EN
    function automatic logic rf_parity(input logic [RF_MAX_BIT-1:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/rf_2r1w_sync_if.sv
// rf_2r1w_sync_if: write port, two read ports and BUSY status (PERRA/PERRB with RF_PARITY_EN)
interface rf_2r1w_sync_if #(
    parameter int numBit     = 8,
    parameter int numRowAddr = 4
);
    logic                  CEBW;
    logic [numRowAddr-1:0] AW;
    logic [numBit-1:0]     D;
    logic [numBit-1:0]     BWEB;
    logic                  CEBA;
    logic [numRowAddr-1:0] AA;
    logic [numBit-1:0]     QA;
    logic                  CEBB;
    logic [numRowAddr-1:0] AB;
    logic [numBit-1:0]     QB;
    logic                  BUSY;
`ifdef RF_PARITY_EN
    logic                  PERRA;
    logic                  PERRB;
`endif

    modport master (
        output CEBW, AW, D, BWEB, CEBA, AA, CEBB, AB,
        input  QA, QB, BUSY
`ifdef RF_PARITY_EN
        , PERRA, PERRB
`endif
    );

    modport slave (
        input  CEBW, AW, D, BWEB, CEBA, AA, CEBB, AB,
        output QA, QB, BUSY
`ifdef RF_PARITY_EN
        , PERRA, PERRB
`endif
    );

endinterface

// File: rtl/rf_2r1w_sync_clear_seq.sv
// rf_clear_seq: post-reset sweep that zeroes every row, holding BUSY until the last row is written
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int numRow     = 16,
    parameter int numRowAddr = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [numRowAddr-1:0] clr_addr
);

    rf_state_e             state_q, state_d;
    logic [numRowAddr-1:0] cnt_q, cnt_d;

    // state and row counter registers; reset restarts the sweep from row 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // advance one row per cycle while clearing, leave after the last row
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == numRowAddr'(numRow - 1)) begin
                state_d = RF_READY;
                cnt_d   = '0;
            end
        end
    end

    assign busy     = state_q == RF_CLEAR;
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/rf_2r1w_sync.sv
// rf_2r1w_sync: 1W/2R register file, masked writes, write-through bypass, clear sweep (RF_PARITY_EN adds row parity)
module rf_2r1w_sync
    import rf_pkg::*;
#(
    parameter int numRow     = 16,
    parameter int numBit     = 8,
    parameter int numRowAddr = 4
) (
    input logic          CLK,
    input logic          RST,
    rf_2r1w_sync_if.slave bus
);

    logic                  busy, clr_we, we, ok_a, ok_b, hit_a, hit_b;
    logic [numRowAddr-1:0] clr_addr;
    logic [numBit-1:0]     wdata;
    logic [numBit-1:0]     mem_q [numRow];
    logic [numBit-1:0]     mem_d [numRow];
    logic [numBit-1:0]     qa_q, qa_d, qb_q, qb_d;

    rf_clear_seq #(.numRow(numRow), .numRowAddr(numRowAddr)) u_clr (
        .clk      (CLK),
        .rst      (RST),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // decode port accesses; out-of-range rows never write and read as zero
    always_comb begin
        we    = !busy && !bus.CEBW && (32'(bus.AW) < numRow);
        ok_a  = 32'(bus.AA) < numRow;
        ok_b  = 32'(bus.AB) < numRow;
        hit_a = we && (bus.AW == bus.AA);
        hit_b = we && (bus.AW == bus.AB);
        wdata = numBit'(rf_merge(RF_MAX_BIT'(mem_q[bus.AW]), RF_MAX_BIT'(bus.D), RF_MAX_BIT'(bus.BWEB)));
    end

    // next row contents: clear sweep has priority over the port write
    always_comb begin
        mem_d = mem_q;
        if (clr_we) mem_d[clr_addr] = '0;
        else if (we) mem_d[bus.AW] = wdata;
    end

    // next read data, bypassing a same-cycle write to the same row
    always_comb begin
        qa_d = busy ? '0 : bus.CEBA ? qa_q : !ok_a ? '0 : hit_a ? wdata : mem_q[bus.AA];
        qb_d = busy ? '0 : bus.CEBB ? qb_q : !ok_b ? '0 : hit_b ? wdata : mem_q[bus.AB];
    end

    // row storage, initialised by the clear sweep rather than reset
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // read output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            qa_q <= '0;
            qb_q <= '0;
        end else begin
            qa_q <= qa_d;
            qb_q <= qb_d;
        end
    end

    assign bus.QA   = qa_q;
    assign bus.QB   = qb_q;
    assign bus.BUSY = busy;

`ifdef RF_PARITY_EN
    logic par_q [numRow];
    logic par_d [numRow];
    logic perra_q, perra_d, perrb_q, perrb_d;

    // parity follows the row: cleared to 0, recomputed from the merged value on write
    always_comb begin
        par_d = par_q;
        if (clr_we) par_d[clr_addr] = 1'b0;
        else if (we) par_d[bus.AW] = rf_parity(RF_MAX_BIT'(wdata));
    end

    // flag stored rows whose parity disagrees; bypassed data is fresh and never flags
    always_comb begin
        perra_d = busy ? 1'b0 : bus.CEBA ? perra_q : (!ok_a || hit_a) ? 1'b0 :
                  par_q[bus.AA] != rf_parity(RF_MAX_BIT'(mem_q[bus.AA]));
        perrb_d = busy ? 1'b0 : bus.CEBB ? perrb_q : (!ok_b || hit_b) ? 1'b0 :
                  par_q[bus.AB] != rf_parity(RF_MAX_BIT'(mem_q[bus.AB]));
    end

    // parity storage
    always_ff @(posedge CLK) begin
        par_q <= par_d;
    end

    // parity error output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            perra_q <= 1'b0;
            perrb_q <= 1'b0;
        end else begin
            perra_q <= perra_d;
            perrb_q <= perrb_d;
        end
    end

    assign bus.PERRA = perra_q;
    assign bus.PERRB = perrb_q;
`endif

endmodule

// File: doc/rf_2r1w_sync.md
Name: rf_2r1w_sync

Overview:
- Parametrised successor to the single-port register-file model.
- One write port with per-bit active-low write mask and two independent registered read ports.
- Write-through bypass on same-address collisions.
- After reset, a hardware clear sequencer zeroes every row before any access is accepted.
- Sits beside the IM core datapath as operand/scratch storage. It is a behavioural RF, not a compiled macro.

Parameters:
- numRow, 16, number of rows; need not be a power of two.
- numBit, 8, row width in bits.
- numRowAddr, 4, address width; must satisfy 2**numRowAddr >= numRow.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- CEBW  input  1  write-port enable, active-low.
- AW  input  numRowAddr  write address.
- D  input  numBit  write data.
- BWEB  input  numBit  per-bit write enable, active-low (bit i written only when BWEB[i]=0).
- CEBA  input  1  read-port A enable, active-low.
- AA  input  numRowAddr  read-port A address.
- QA  output  numBit  read-port A data, registered.
- CEBB  input  1  read-port B enable, active-low.
- AB  input  numRowAddr  read-port B address.
- QB  output  numBit  read-port B data, registered.
- BUSY  output  1  clear sweep in progress; all port enables are ignored while high.

Behaviour:
- Reset: while RST=1 at a posedge, FSM goes to CLEAR, clear counter goes to 0, and QA=QB=0. BUSY=1 during and after reset.
- FSM states:
  - CLEAR: writes row[cnt]=0, then cnt++. When cnt==numRow-1 the row is written and the FSM moves to READY.
  - READY: normal operation.
  - BUSY=(state==CLEAR). BUSY stays high exactly numRow cycles after RST deasserts.
- RST reasserted mid-clear: the sweep restarts from row 0.
- Write (READY, CEBW=0, AW<numRow): row[AW] <= (row[AW] & BWEB) | (D & ~BWEB).
  - BWEB all ones: no change.
  - CEBW=1: D, AW and BWEB are don't-care.
- Reads (READY, CEBx=0): Qx <= row[Ax] at posedge, giving 1-cycle latency.
  - CEBx=1: Qx holds its previous value.
  - Ports A and B are fully independent; the same address on both is legal.
- Write-through bypass: if a read and a write to the same valid address fall in the same cycle, Qx gets the merged new row value, not the old contents.
- Out-of-range address (>=numRow, only possible when numRow is not a power of two):
  - Write is dropped.
  - Read returns 0.
  - No X propagation.
- While BUSY=1: writes dropped, QA/QB hold 0.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: RF_PARITY_EN.
- Enabled:
  - Each row stores an extra even-parity bit computed on the post-merge row value at write time. The clear sweep writes parity 0.
  - Adds outputs PERRA and PERRB (1 bit each, registered alongside Qx).
  - PERRx=1 when the read row's stored parity mismatches its data. Bypassed reads never flag.
  - PERRx reset value is 0.
- Disabled: no parity storage and no PERR ports.

Decomposition:
- Package rf_pkg holds:
  - state enum rf_state_e {RF_CLEAR, RF_READY}.
  - function rf_merge(old, d, bweb) for the mask merge.
  - function rf_parity(data) (under the macro).
- One sub-module, rf_clear_seq: FSM plus row counter, outputs BUSY, the clear write enable and the clear address. The top muxes clear-write over port-write.

Test Plan:
- Reset with numRow=16: pulse RST for 2 cycles -> BUSY=1 for exactly 16 cycles after deassertion. Then read all rows on A and B -> all 0x00.
- Masked write: row 5=0xFF, then write D=0x00, BWEB=0xF0 to row 5; read A5 next cycle -> QA=0xF0.
- Bypass and independence: same cycle write AW=3, D=0xA5, BWEB=0x00 with reads AA=3, AB=3 -> next cycle QA=QB=0xA5. With AB=4 (holding 0x11) -> QB=0x11.
- Hold and ignore: CEBA=1 for 3 cycles -> QA unchanged. Writes and reads attempted while BUSY=1 -> no row modified, QA=QB=0.
- Mid-clear reset and non-power-of-two depth, numRow=12, numRowAddr=4:
  - RST at clear cycle 6 -> sweep restarts, BUSY high for 12 more cycles.
  - Write to address 13 -> dropped; read address 13 -> 0.
- RF_PARITY_EN: write 0x3C to row 2, force-flip stored data bit 0, read row 2 -> PERRA=1. Clean row 7 read -> PERRA=0.
